// File: rtl/vin_pkg.sv
// Shared types for the video-input timing lock block.
//   VIN_CNT_W    : default width of timing counters and measurement fields
//   vin_state_e  : lock FSM states
//   vin_timing_t : one frame's raster timing (reference, candidate, published)
package vin_pkg;

  localparam int unsigned VIN_CNT_W = 12;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } vin_state_e;

  typedef struct packed {
    logic [VIN_CNT_W-1:0] hact;
    logic [VIN_CNT_W-1:0] htotal;
    logic [VIN_CNT_W-1:0] vact;
    logic [VIN_CNT_W-1:0] vtotal;
  } vin_timing_t;

endpackage

// File: rtl/vin_edge_det.sv
// Registers a sync input once and flags its rising edge.
//   clk, rst_n : pixel clock, async active-low reset
//   d          : raw sync input
//   q          : registered copy of d
//   rise       : high for one cycle when q goes 0->1 (one cycle after d)
module vin_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;

  always_comb begin
    cur_d  = d;
    prev_d = cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  assign q    = cur_q;
  assign rise = cur_q & ~prev_q;

endmodule

// File: rtl/vin_timing_lock.sv
// Measures incoming raster timing per frame, declares lock after LOCK_FRAMES
// identical frames and passes vsync/de downstream only while locked.
//   clk, rst_n          : pixel clock (2 pixels/clock), async active-low reset
//   v_vsync/v_hsync/v_de/v_pixel : video from the input stage
//   o_vsync/o_de        : registered, gated by lock
//   o_hsync/o_pixel     : registered, ungated
//   t_hact/t_htotal/t_vact/t_vtotal : timing of last locked frame
//   locked, timing_err  : lock status, one-cycle pulse on loss/mismatch
// The timing record fields are VIN_CNT_W wide; CNT_W must match it.
module vin_timing_lock import vin_pkg::*; #(
  parameter int unsigned CNT_W       = VIN_CNT_W,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_vsync,
  input  logic             v_hsync,
  input  logic             v_de,
  input  logic [47:0]      v_pixel,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [47:0]      o_pixel,
  output logic [CNT_W-1:0] t_hact,
  output logic [CNT_W-1:0] t_htotal,
  output logic [CNT_W-1:0] t_vact,
  output logic [CNT_W-1:0] t_vtotal,
  output logic             locked,
  output logic             timing_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       MATCH_MAX = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic hs_q, hs_rise, vs_q, vs_rise;

  vin_edge_det u_hs_det (.clk(clk), .rst_n(rst_n), .d(v_hsync), .q(hs_q), .rise(hs_rise));
  vin_edge_det u_vs_det (.clk(clk), .rst_n(rst_n), .d(v_vsync), .q(vs_q), .rise(vs_rise));

  logic             de_q, de_d;
  logic [47:0]      pix_q, pix_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d;
  logic [CNT_W-1:0] vact_q, vact_d, line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] first_hact_q, first_hact_d, htotal_q, htotal_d;
  logic             bad_q, bad_d;
  vin_state_e       state_q, state_d;
  vin_timing_t      ref_q, ref_d, t_q, t_d, cand;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d, err_q, err_d;

  // Post-line-close values, so a coincident vsync sees the updated counts.
  logic [CNT_W-1:0] line_htotal, line_hact, vact_ln, line_cnt_ln, first_hact_ln, htotal_ln;
  logic             bad_ln, h_loss, cand_ok;

  always_comb begin
    de_d  = v_de;
    pix_d = v_pixel;

    // Line stage
    h_cnt_d       = sat_inc(h_cnt_q);
    de_cnt_d      = de_q ? sat_inc(de_cnt_q) : de_cnt_q;
    line_htotal   = '0;
    line_hact     = '0;
    vact_ln       = vact_q;
    line_cnt_ln   = line_cnt_q;
    first_hact_ln = first_hact_q;
    htotal_ln     = htotal_q;
    bad_ln        = bad_q;
    h_loss        = 1'b0;
    if (hs_rise) begin
      line_htotal = sat_inc(h_cnt_q);
      line_hact   = de_cnt_d;  // DE in the rise cycle belongs to the closing line
      htotal_ln   = line_htotal;
      if (line_hact != '0) begin
        if (vact_q == '0) first_hact_ln = line_hact;
        else if (line_hact != first_hact_q) bad_ln = 1'b1;
        vact_ln = sat_inc(vact_q);
      end
      line_cnt_ln = sat_inc(line_cnt_q);
      h_cnt_d     = '0;
      de_cnt_d    = '0;
    end else begin
      h_loss = (h_cnt_d == CNT_MAX);
    end
    if (h_cnt_d == CNT_MAX || de_cnt_d == CNT_MAX || line_htotal == CNT_MAX ||
        line_hact == CNT_MAX || vact_ln == CNT_MAX || line_cnt_ln == CNT_MAX)
      bad_ln = 1'b1;

    cand.hact   = first_hact_ln;
    cand.htotal = htotal_ln;
    cand.vact   = vact_ln;
    cand.vtotal = line_cnt_ln;
    cand_ok     = (cand.hact != '0) && (cand.htotal != '0) &&
                  (cand.vact != '0) && (cand.vtotal != '0);

    // Frame stage
    vact_d       = vact_ln;
    line_cnt_d   = line_cnt_ln;
    first_hact_d = first_hact_ln;
    htotal_d     = htotal_ln;
    bad_d        = bad_ln;
    if (vs_rise) begin
      vact_d       = '0;
      line_cnt_d   = '0;
      first_hact_d = '0;
      htotal_d     = '0;
      bad_d        = 1'b0;
    end

    // Lock FSM
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    locked_d = locked_q;
    t_d      = t_q;
    err_d    = 1'b0;
    unique case (state_q)
      SEARCH: if (vs_rise) state_d = MEASURE;
      MEASURE: begin
        if (vs_rise && !bad_ln && cand_ok) begin
          ref_d   = cand;
          match_d = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (h_loss) begin
          locked_d = 1'b0;
          err_d    = 1'b1;
          match_d  = '0;
          state_d  = SEARCH;
        end else if (vs_rise) begin
          if (!bad_ln && cand == ref_q) begin
            if (match_q != MATCH_MAX) match_d = match_q + 4'd1;
            if (match_d == MATCH_MAX) begin
              locked_d = 1'b1;
              t_d      = cand;
            end
          end else begin
            ref_d    = cand;
            match_d  = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q         <= 1'b0;
      pix_q        <= '0;
      h_cnt_q      <= '0;
      de_cnt_q     <= '0;
      vact_q       <= '0;
      line_cnt_q   <= '0;
      first_hact_q <= '0;
      htotal_q     <= '0;
      bad_q        <= 1'b0;
      state_q      <= SEARCH;
      ref_q        <= '0;
      t_q          <= '0;
      match_q      <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      de_q         <= de_d;
      pix_q        <= pix_d;
      h_cnt_q      <= h_cnt_d;
      de_cnt_q     <= de_cnt_d;
      vact_q       <= vact_d;
      line_cnt_q   <= line_cnt_d;
      first_hact_q <= first_hact_d;
      htotal_q     <= htotal_d;
      bad_q        <= bad_d;
      state_q      <= state_d;
      ref_q        <= ref_d;
      t_q          <= t_d;
      match_q      <= match_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  // vs_q/de_q and locked_q load on the same edge, so this equals a
  // register of (input & next lock state).
  assign o_vsync    = vs_q & locked_q;
  assign o_de       = de_q & locked_q;
  assign o_hsync    = hs_q;
  assign o_pixel    = pix_q;
  assign t_hact     = t_q.hact;
  assign t_htotal   = t_q.htotal;
  assign t_vact     = t_q.vact;
  assign t_vtotal   = t_q.vtotal;
  assign locked     = locked_q;
  assign timing_err = err_q;

endmodule

// File: doc/vin_timing_lock.md
Name: vin_timing_lock

Overview:
- Sits directly downstream of the FPD-Link video input stage, clocked by its pixel clock (2 pixels/clock).
- Measures incoming raster timing per frame: horizontal active/total in clocks, vertical active/total in lines.
- Declares lock after LOCK_FRAMES consecutive identical frames and passes video downstream only while locked, so the display pipeline never sees a partial or unstable frame.
- Exposes measured timing to the control CPU as status registers.

Parameters:
- CNT_W, 12, width of all timing counters and measurement outputs.
- LOCK_FRAMES, 3, consecutive matching frames required before lock (1..15).

Ports:
- clk  in  1  pixel clock (same as input stage pclk)
- rst_n  in  1  reset, asynchronous, active-low
- v_vsync  in  1  vertical sync, active-high
- v_hsync  in  1  horizontal sync, active-high
- v_de  in  1  data enable
- v_pixel  in  48  two RGB888 pixels
- o_vsync  out  1  registered vsync, gated by locked
- o_hsync  out  1  registered hsync, ungated
- o_de  out  1  registered de, gated by locked
- o_pixel  out  48  registered pixel data, ungated
- t_hact  out  CNT_W  DE-high clocks per active line, last completed frame
- t_htotal  out  CNT_W  clocks between hsync rising edges
- t_vact  out  CNT_W  lines containing DE in last frame
- t_vtotal  out  CNT_W  lines between vsync rising edges
- locked  out  1  timing stable
- timing_err  out  1  one-cycle pulse on lock loss or mismatch

Behaviour:
- Reset: all outputs 0; FSM in SEARCH; all counters 0.
- Edges: each sync is registered once; a rising edge is current=1 and previous=0. Measurement sees edges 1 cycle after the input.
- Data path: o_* are registered copies of the v_* inputs, 1-cycle latency.
  - o_de = v_de & locked, sampled in the same cycle.
  - o_vsync = v_vsync & locked.
- Line counters:
  - h_cnt increments every clock; de_cnt increments when de=1.
  - On hsync rise, the line closes:
    - line_htotal = h_cnt + 1.
    - If de_cnt != 0: line is active, v_act_cnt increments, and line_hact is compared with the first active line's hact in this frame. Any difference sets frame_bad.
    - Both counters then clear.
  - line_cnt increments on each hsync rise.
- Saturation: any counter reaching all-ones holds there and sets frame_bad.
  - h_cnt saturation with no hsync means no hsync present. In TRACK it forces immediate lock loss: locked=0, timing_err=1, FSM to SEARCH. This may cut a frame mid-line; that is intended.
- Frame close on vsync rise:
  - If hsync also rises in the same cycle, the line closes first, then the frame closes using the updated line count.
  - Candidate = {hact, htotal, vact, vtotal = line_cnt}.
  - All frame counters and frame_bad clear afterwards.
- FSM:
  - SEARCH: on first vsync rise -> MEASURE. The partial frame is discarded.
  - MEASURE: on vsync rise, if !frame_bad and all candidate fields are nonzero, store the candidate as reference, set match=0, go to TRACK. Otherwise stay.
  - TRACK: on vsync rise, a match requires candidate == reference and !frame_bad.
    - On match: match++. When match reaches LOCK_FRAMES, set locked=1 and publish t_*.
    - On mismatch: the candidate becomes the new reference, match=0.
      - If locked was 1: locked=0 and timing_err pulses.
      - If not locked: timing_err pulses too.
- t_* update only at a frame close while locked (including the locking frame). Otherwise they hold their value.
- locked changes only at vsync rise, except on h_cnt saturation.
- match saturates at LOCK_FRAMES.
- Async reset mid-frame returns to SEARCH immediately. No outputs are asserted until a full relock.

Decomposition:
- Shared package vin_pkg:
  - Default CNT_W.
  - FSM state enum {SEARCH, MEASURE, TRACK}.
  - Timing record type {hact, htotal, vact, vtotal}, used for the reference, candidate, and outputs.
- One sub-module, vin_edge_det: 1-bit register plus rising-edge pulse, instantiated for hsync and vsync.
- Everything else inline.

Test Plan:
- Stable raster, hact=800, htotal=840, vact=1200, vtotal=1210:
  - locked rises 1 cycle after the 5th vsync rise (SEARCH, MEASURE, 3 matches).
  - t_* then read 800/840/1200/1210.
  - o_de is 0 before lock and mirrors v_de 1 cycle later after lock.
- After lock, one frame with vtotal=1211:
  - At its vsync rise: locked=0, timing_err pulses exactly 1 cycle, t_* hold their old values.
  - Relock 3 frames later, with t_vtotal=1211 if the new timing persists.
- One line within a frame with hact=799:
  - That frame is not counted as a match; lock is not declared on it.
  - When locked: lock lost and timing_err pulses.
- hsync held low after lock with CNT_W=12:
  - After 4095 clocks, locked=0 and timing_err pulses with no vsync edge.
  - o_de forced to 0 in the same cycle.
- hsync and vsync rising in the same cycle, steady:
  - vtotal counts that line; lock is still achieved with t_vtotal=1210.
- rst_n asserted mid-frame while locked:
  - locked, o_de and t_* go to 0 asynchronously.
  - After release, lock requires the full 5 vsync edges again.
